// File: rtl/bit32_1to2demux_buf.sv
// Buffered 32-bit 1-to-2 demux: one input stream routed by sel into two independent output FIFOs.
// Optional per-output delivery counters (out1_cnt/out2_cnt) when BIT32_DEMUX_CNT_EN is defined.
module bit32_1to2demux_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        sel,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [31:0] out1_data,
  output logic        out2_valid,
  input  logic        out2_ready,
  output logic [31:0] out2_data
`ifdef BIT32_DEMUX_CNT_EN
  ,
  output logic [15:0] out1_cnt,
  output logic [15:0] out2_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [AW-1:0]     wr1, rd1, wr2, rd2;
  logic [AW:0]       cnt1, cnt2;
  logic              full1, full2;
  logic              push1, push2, pop1, pop2;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  function automatic logic [AW:0] cnt_next(input logic [AW:0] cnt,
                                           input logic push, input logic pop);
    logic [AW:0] r;
    r = cnt;
    if (push && !pop) r = cnt + 1'b1;
    else if (!push && pop) r = cnt - 1'b1;
    return r;
  endfunction

  assign full1 = (cnt1 == FULL_CNT);
  assign full2 = (cnt2 == FULL_CNT);

  // Full is judged on the registered count, so a pop in the same cycle cannot free a slot.
  assign in_ready   = sel ? !full2 : !full1;
  assign push1      = in_valid && in_ready && !sel;
  assign push2      = in_valid && in_ready &&  sel;

  assign out1_valid = (cnt1 != '0);
  assign out2_valid = (cnt2 != '0);
  assign out1_data  = mem1[rd1];
  assign out2_data  = mem2[rd2];
  assign pop1       = out1_valid && out1_ready;
  assign pop2       = out2_valid && out2_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr1  <= '0;
      rd1  <= '0;
      cnt1 <= '0;
      for (int i = 0; i < DEPTH; i++) mem1[i] <= '0;
    end else begin
      if (push1) begin
        mem1[wr1] <= in_data;
        wr1       <= wr1 + 1'b1;
      end
      if (pop1) rd1 <= rd1 + 1'b1;
      cnt1 <= cnt_next(cnt1, push1, pop1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr2  <= '0;
      rd2  <= '0;
      cnt2 <= '0;
      for (int i = 0; i < DEPTH; i++) mem2[i] <= '0;
    end else begin
      if (push2) begin
        mem2[wr2] <= in_data;
        wr2       <= wr2 + 1'b1;
      end
      if (pop2) rd2 <= rd2 + 1'b1;
      cnt2 <= cnt_next(cnt2, push2, pop2);
    end
  end

`ifdef BIT32_DEMUX_CNT_EN
  // Delivery counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      out1_cnt <= '0;
      out2_cnt <= '0;
    end else begin
      if (pop1) out1_cnt <= out1_cnt + 16'd1;
      if (pop2) out2_cnt <= out2_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit32_1to2demux_buf.sv
// Bench for bit32_1to2demux_buf: directed plan plus random traffic against a queue-based model.
// Counter ports are exercised when BIT32_DEMUX_CNT_EN is defined.
module tb_bit32_1to2demux_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sel;
  logic        out1_valid, out1_ready;
  logic [31:0] out1_data;
  logic        out2_valid, out2_ready;
  logic [31:0] out2_data;
`ifdef BIT32_DEMUX_CNT_EN
  logic [15:0] out1_cnt, out2_cnt;
`endif

  bit32_1to2demux_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data)
`ifdef BIT32_DEMUX_CNT_EN
    ,
    .out1_cnt   (out1_cnt),
    .out2_cnt   (out2_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each output is an ordered queue of at most DEPTH words.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        z1, z2;       // storage still all-zero since reset
  logic [15:0] c1, c2;
  logic        last_push;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    z1 = 1'b1;
    z2 = 1'b1;
    c1 = '0;
    c2 = '0;
  endtask

  // Check outputs against the model, clock once, and advance the model.
  task automatic tick();
    logic        er, p1, p2, o1, o2;
    logic [31:0] d;
    #1;
    er = sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
    chk("out2_valid", {31'b0, out2_valid}, {31'b0, q2.size() != 0});
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    else if (z1)        chk("out1_data_zero", out1_data, 32'h0);
    if (q2.size() != 0) chk("out2_data", out2_data, q2[0]);
    else if (z2)        chk("out2_data_zero", out2_data, 32'h0);
`ifdef BIT32_DEMUX_CNT_EN
    chk("out1_cnt", {16'b0, out1_cnt}, {16'b0, c1});
    chk("out2_cnt", {16'b0, out2_cnt}, {16'b0, c2});
`endif
    d  = in_data;
    p1 = !reset && in_valid && er && !sel;
    p2 = !reset && in_valid && er &&  sel;
    o1 = !reset && (q1.size() != 0) && out1_ready;
    o2 = !reset && (q2.size() != 0) && out2_ready;
    last_push = p1 | p2;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else begin
      if (o1) begin void'(q1.pop_front()); c1 = c1 + 16'd1; end
      if (o2) begin void'(q2.pop_front()); c2 = c2 + 16'd1; end
      if (p1) begin q1.push_back(d); z1 = 1'b0; end
      if (p2) begin q2.push_back(d); z2 = 1'b0; end
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2);
    in_valid   = v;
    sel        = s;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  initial begin
    int idx;
    int budget;
    last_push = 1'b0;
    // Reset for two cycles with a word offered; it must be dropped.
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
    chk("rst_out1_data", out1_data, 32'h0);
    chk("rst_out2_data", out2_data, 32'h0);
    reset = 1'b0;

    // Basic routing.
    drive(1'b1, 1'b0, 32'h0123_4567, 1'b1, 1'b1);
    tick();
    chk("route1_valid", {31'b0, out1_valid}, 32'd1);
    chk("route1_data", out1_data, 32'h0123_4567);
    chk("route1_other", {31'b0, out2_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'h89AB_CDEF, 1'b1, 1'b1);
    tick();
    chk("route2_valid", {31'b0, out2_valid}, 32'd1);
    chk("route2_data", out2_data, 32'h89AB_CDEF);
    chk("route2_other", {31'b0, out1_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();

    // Full and isolation.
    drive(1'b1, 1'b0, 32'hA0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b1);
    #1;
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("full_head", out1_data, 32'hA0);
    drive(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
    tick();
    chk("iso_b0_valid", {31'b0, out2_valid}, 32'd1);
    chk("iso_b0_data", out2_data, 32'hB0);
    drive(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1);
    budget = 0;
    while (q1.size() != 0 || in_valid) begin
      tick();
      if (last_push) in_valid = 1'b0;
      budget++;
      if (budget > 20) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end

    // Wrap-around on output 2 with toggling consumer.
    idx = 0;
    budget = 0;
    drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    while ((idx < 10 || q2.size() != 0) && budget < 200) begin
      in_valid   = (idx < 10);
      in_data    = idx;
      out2_ready = ~out2_ready;
      tick();
      if (last_push) idx++;
      budget++;
    end
    chk("wrap_count", idx, 32'd10);
    chk("wrap_drained", {31'b0, out2_valid}, 32'd0);

    // Simultaneous push/pop at full: push is refused, then succeeds.
    drive(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hC2, 1'b1, 1'b0);
    #1;
    chk("pp_full_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("pp_after_valid", {31'b0, out1_valid}, 32'd1);
    chk("pp_after_head", out1_data, 32'hC1);
    out1_ready = 1'b0;
    #1;
    chk("pp_retry_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("pp_retry_pushed", {31'b0, last_push}, 32'd1);

    // Mid-operation reset with both FIFOs holding data and a word offered.
    drive(1'b1, 1'b1, 32'hE0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'hE1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("mrst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("mrst_out2_valid", {31'b0, out2_valid}, 32'd0);
`ifdef BIT32_DEMUX_CNT_EN
    chk("mrst_cnt1", {16'b0, out1_cnt}, 32'd0);
    chk("mrst_cnt2", {16'b0, out2_cnt}, 32'd0);
`endif
    tick();

    // Random traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
